rd_fram_buf: RTL and testbench
==============================

RD_FRAM_BUF -- requirements
Module: rd_fram_buf

Interface
REQ-001 DATA_WIDTH, 128, word width of both ports.
REQ-002 ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH words (1024 by default).
REQ-003 ddr_clk  input  1  single clock for both ports; all logic rising-edge.
REQ-004 ddr_rstn  input  1  reset, synchronous, active-low.
REQ-005 a_addr  input  ADDR_WIDTH  port A address.
REQ-006 a_wr_data  input  DATA_WIDTH  port A write data.
REQ-007 a_wr_en  input  1  port A write enable.
REQ-008 a_rd_data  output  DATA_WIDTH  port A registered read data.
REQ-009 b_addr  input  ADDR_WIDTH  port B address.
REQ-010 b_wr_data  input  DATA_WIDTH  port B write data.
REQ-011 b_wr_en  input  1  port B write enable.
REQ-012 b_rd_data  output  DATA_WIDTH  port B registered read data.

Function
REQ-013 The block SHALL be a true dual-port RAM of 2^ADDR_WIDTH x DATA_WIDTH bits; both ports read and write independently every cycle.
REQ-014 Write: when x_wr_en=1 and ddr_rstn=1 at a rising edge, mem[x_addr] SHALL take x_wr_data at that edge.
REQ-015 Read: each port SHALL read every cycle regardless of wr_en; x_rd_data SHALL equal mem[x_addr] as sampled at edge N, visible after edge N (1-cycle latency); with OUT_REG enabled, visible after edge N+1.
REQ-016 Same-port read-during-write SHALL be read-first: x_rd_data returns the old contents, and the new data is readable from the next access.
REQ-017 Cross-port read of an address written the same cycle by the other port SHALL return the old contents (read-first).
REQ-018 Both ports writing the same address in the same cycle SHALL store a_wr_data (port A wins); each port's read data SHALL return the old contents.
REQ-019 Addresses SHALL be used in full with no wrap logic; address 2^ADDR_WIDTH-1 is the last word. Callers incrementing addresses wrap naturally modulo 2^ADDR_WIDTH.
REQ-020 Memory contents SHALL be undefined after power-up; no initialisation is required.

Reset
REQ-021 While ddr_rstn=0 at a rising edge, a_rd_data and b_rd_data SHALL be forced to 0, along with the OUT_REG stage registers when present.
REQ-022 While ddr_rstn=0, writes on both ports SHALL be suppressed, and memory contents SHALL be retained, not cleared.
REQ-023 On the first edge with ddr_rstn=1, normal reads and writes SHALL resume with no extra wait state.
REQ-024 Reset asserted mid-operation SHALL abort only the current edge's write; earlier writes persist.

Configuration
REQ-025 Macro RD_FRAM_BUF_OUT_REG_EN: when defined, both ports SHALL add one output pipeline register after the RAM read register, giving 2-cycle read latency; this stage is reset to 0 by ddr_rstn.
REQ-026 When RD_FRAM_BUF_OUT_REG_EN is undefined, read latency SHALL be exactly 1 cycle and no extra register is present.

Verification
REQ-027 Reset: hold ddr_rstn=0 for 3 cycles with a_wr_en=1, a_addr=5, a_wr_data=all-ones -> both rd_data=0; after release, reading address 5 does not return all-ones unless it was written before.
REQ-028 Write then read: port A writes addr k with data 128'h{k replicated} for k=0..1023, then port B reads 0..1023 -> b_rd_data matches every word, 1 cycle after each address (2 with the macro), including addr 1023.
REQ-029 Read-first: mem[7]=0xAA..AA, then port A writes 0x55..55 to addr 7 while port A and port B both read addr 7 -> both return 0xAA..AA; the next read returns 0x55..55.
REQ-030 Write collision: in the same cycle, A writes 0x11..11 and B writes 0x22..22 to addr 100 -> a later read of addr 100 on either port returns 0x11..11.
REQ-031 Reset mid-stream: port A writes addr 0..9 with reset pulsed low during the write to addr 5 -> addr 5 keeps its old value; addr 0..4 and 6..9 hold the new data.
REQ-032 Streaming: port A writes a continuous burst with a_wr_en=1 every cycle while port B reads continuously with a lag of 4 addresses -> no data mismatches.

Source files
------------

// File: rtl/rd_fram_buf.sv
// -----------------------------------------------------------------------------
// rd_fram_buf -- true dual-port frame buffer RAM, 2^ADDR_WIDTH x DATA_WIDTH.
//
// Both ports read and write independently on every rising edge of ddr_clk.
// Reads are registered (1-cycle latency) and read-first: a read of an address
// being written in the same cycle, by either port, returns the old contents.
// When both ports write the same address in the same cycle, port A's data is
// stored.
//
// Optional build macro:
//   RD_FRAM_BUF_OUT_REG_EN  adds one more output register per port, giving
//                           2-cycle read latency. The extra stage is cleared
//                           by reset.
//
// Ports:
//   ddr_clk    in   1           clock, all logic on the rising edge
//   ddr_rstn   in   1           synchronous active-low reset; clears read data
//                               registers and blocks writes; RAM contents are
//                               retained
//   a_addr     in   ADDR_WIDTH  port A address
//   a_wr_data  in   DATA_WIDTH  port A write data
//   a_wr_en    in   1           port A write enable
//   a_rd_data  out  DATA_WIDTH  port A registered read data
//   b_addr     in   ADDR_WIDTH  port B address
//   b_wr_data  in   DATA_WIDTH  port B write data
//   b_wr_en    in   1           port B write enable
//   b_rd_data  out  DATA_WIDTH  port B registered read data
// -----------------------------------------------------------------------------
module rd_fram_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rstn,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  b_wr_en,
  output logic [DATA_WIDTH-1:0] b_rd_data
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NPORTS = 2;

  // Contents are intentionally left uninitialised.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-port views so both read paths come from one generate loop.
  logic [ADDR_WIDTH-1:0] port_addr [NPORTS];
  logic [DATA_WIDTH-1:0] port_dout [NPORTS];

  assign port_addr[0] = a_addr;
  assign port_addr[1] = b_addr;

  // Both writes live in one process so the array has a single driver.
  // Port A is applied last, so it wins an address collision.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rstn) begin
      if (b_wr_en) begin
        mem[b_addr] <= b_wr_data;
      end
      if (a_wr_en) begin
        mem[a_addr] <= a_wr_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [DATA_WIDTH-1:0] rd_q;

      // Non-blocking read of the array gives read-first behaviour against
      // writes from either port on the same edge.
      always_ff @(posedge ddr_clk) begin
        if (!ddr_rstn) begin
          rd_q <= '0;
        end else begin
          rd_q <= mem[port_addr[gi]];
        end
      end

`ifdef RD_FRAM_BUF_OUT_REG_EN
      logic [DATA_WIDTH-1:0] out_q;
      logic [DATA_WIDTH-1:0] out_d;

      assign out_d = rd_q;

      always_ff @(posedge ddr_clk) begin
        if (!ddr_rstn) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign port_dout[gi] = out_q;
`else
      assign port_dout[gi] = rd_q;
`endif
    end
  endgenerate

  assign a_rd_data = port_dout[0];
  assign b_rd_data = port_dout[1];

endmodule

// File: tb/tb_rd_fram_buf.sv
// -----------------------------------------------------------------------------
// tb_rd_fram_buf -- scoreboard bench for rd_fram_buf.
// A driver issues one transaction per cycle and pushes the expected read data,
// computed from a plain array model of the RAM, into a queue. A monitor pops
// and compares after every edge once the read latency has elapsed.
// -----------------------------------------------------------------------------
module tb_rd_fram_buf;

  localparam int DW = 128;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
`ifdef RD_FRAM_BUF_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rstn;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wr_data;
  logic          a_wr_en;
  logic [DW-1:0] a_rd_data;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wr_data;
  logic          b_wr_en;
  logic [DW-1:0] b_rd_data;

  rd_fram_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ddr_clk   (clk),
    .ddr_rstn  (rstn),
    .a_addr    (a_addr),
    .a_wr_data (a_wr_data),
    .a_wr_en   (a_wr_en),
    .a_rd_data (a_rd_data),
    .b_addr    (b_addr),
    .b_wr_data (b_wr_data),
    .b_wr_en   (b_wr_en),
    .b_rd_data (b_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          a_chk;
    bit          b_chk;
    bit          a_no1;
    bit          b_no1;
    logic [DW-1:0] a_exp;
    logic [DW-1:0] b_exp;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the RAM as an array plus a "has been written" flag.
  logic [DW-1:0] model_mem [DEPTH];
  bit            known     [DEPTH];

  int n_cmp = 0;
  int n_err = 0;
  int tag_cnt = 0;

  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] rep_word(input int k);
    logic [15:0] h;
    h = 16'(k);
    return {8{h}};
  endfunction

  // One transaction per cycle: drive at the falling edge, record expectations.
  task automatic step(input logic rst_n,
                      input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    exp_t e;
    exp_t prev;
    @(negedge clk);
    rstn      = rst_n;
    a_wr_en   = awe;
    a_addr    = aa;
    a_wr_data = ad;
    b_wr_en   = bwe;
    b_addr    = ba;
    b_wr_data = bd;
    e.tag   = tag_cnt;
    tag_cnt = tag_cnt + 1;
    e.a_no1 = 1'b0;
    e.b_no1 = 1'b0;
    if (!rst_n) begin
      e.a_chk = 1'b1;
      e.b_chk = 1'b1;
      e.a_exp = '0;
      e.b_exp = '0;
      // With the extra output stage, a reset edge also wipes the read that
      // was still in flight, so that one must show zero too.
      if (LAT == 2 && exp_q.size() > 0) begin
        prev = exp_q.pop_back();
        prev.a_chk = 1'b1;
        prev.b_chk = 1'b1;
        prev.a_no1 = 1'b0;
        prev.b_no1 = 1'b0;
        prev.a_exp = '0;
        prev.b_exp = '0;
        exp_q.push_back(prev);
      end
    end else begin
      // Reads see the contents from before this edge's writes.
      e.a_chk = known[aa];
      e.b_chk = known[ba];
      e.a_no1 = !known[aa];
      e.b_no1 = !known[ba];
      e.a_exp = model_mem[aa];
      e.b_exp = model_mem[ba];
      if (bwe) begin
        model_mem[ba] = bd;
        known[ba]     = 1'b1;
      end
      if (awe) begin
        model_mem[aa] = ad;
        known[aa]     = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: after each edge, the oldest entry whose latency has elapsed is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() >= LAT) begin
        e = exp_q.pop_front();
        if (e.a_chk) begin
          n_cmp++;
          if (a_rd_data !== e.a_exp) begin
            n_err++;
            $display("FAIL a_rd tag=%0d got %h want %h", e.tag, a_rd_data, e.a_exp);
          end
        end
        if (e.b_chk) begin
          n_cmp++;
          if (b_rd_data !== e.b_exp) begin
            n_err++;
            $display("FAIL b_rd tag=%0d got %h want %h", e.tag, b_rd_data, e.b_exp);
          end
        end
        if (e.a_no1) begin
          n_cmp++;
          if (a_rd_data === ONES) begin
            n_err++;
            $display("FAIL a_unwritten tag=%0d got %h want not all-ones", e.tag, a_rd_data);
          end
        end
        if (e.b_no1) begin
          n_cmp++;
          if (b_rd_data === ONES) begin
            n_err++;
            $display("FAIL b_unwritten tag=%0d got %h want not all-ones", e.tag, b_rd_data);
          end
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] base;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] w55;
    logic [DW-1:0] waa;
    logic [DW-1:0] w11;
    logic [DW-1:0] w22;
    waa = {(DW/8){8'hAA}};
    w55 = {(DW/8){8'h55}};
    w11 = {(DW/8){8'h11}};
    w22 = {(DW/8){8'h22}};
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      known[i]     = 1'b0;
    end
    rstn = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
    a_addr = '0; b_addr = '0; a_wr_data = '0; b_wr_data = '0;

    // Reset with a write attempt to address 5: outputs zero, write blocked.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'd5, ONES, 1'b0, 10'd5, '0);
    step(1'b1, 1'b0, 10'd5, '0, 1'b0, 10'd5, '0);

    // Fill through port A while port B reads random addresses.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, AW'(k), rep_word(k), 1'b0, AW'($urandom), '0);
    // Read everything back on port B, A reads random addresses.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, AW'($urandom), '0, 1'b0, AW'(k), '0);

    // Read-first on address 7, both ports.
    step(1'b1, 1'b1, 10'd7, waa, 1'b0, 10'd0, '0);
    step(1'b1, 1'b1, 10'd7, w55, 1'b0, 10'd7, '0);
    step(1'b1, 1'b0, 10'd7, '0, 1'b0, 10'd7, '0);

    // Write collision on address 100.
    step(1'b1, 1'b1, 10'd100, w11, 1'b1, 10'd100, w22);
    step(1'b1, 1'b0, 10'd100, '0, 1'b0, 10'd100, '0);

    // Reset pulse during the write to address 5.
    for (int k = 0; k < 10; k++) step((k == 5) ? 1'b0 : 1'b1, 1'b1, AW'(k), rand_word(), 1'b0, AW'(k), '0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, AW'(k), '0, 1'b0, AW'(9 - k), '0);

    // Streaming: B trails A by four addresses, wrapping through the top.
    base = AW'(DEPTH - 100);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, base + AW'(i), rand_word(), 1'b0, base + AW'(i) - AW'(4), '0);

    // Random mix on a small address window to provoke collisions and resets.
    for (int i = 0; i < 3000; i++) begin
      ra = AW'($urandom_range(0, 15));
      rb = AW'($urandom_range(0, 15));
      step(($urandom_range(0, 49) != 0), 1'($urandom), ra, rand_word(),
           1'($urandom), rb, rand_word());
    end

    // Drain the pipeline.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd7, '0, 1'b0, 10'd100, '0);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
